// File: rtl/fir_decim_pkg.sv
// Shared definitions for the decimating FIR: FSM states, Q-format defaults
// and the truncate-toward-zero dequantizer.
package fir_decim_pkg;

  localparam int unsigned MAX_TAPS    = 32;
  localparam int unsigned AUDIO_DECIM = 8;
  localparam int unsigned Q_W         = 32;
  localparam int unsigned Q_BITS      = 10;
  localparam int unsigned MAX_W       = 64;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    OUT     = 2'd2
  } fir_state_t;

  // Divide by 2^bits rounding toward zero; negative inputs get a bias so the
  // arithmetic shift does not floor.
  function automatic logic signed [MAX_W-1:0] deq(input logic signed [MAX_W-1:0] p,
                                                  input int unsigned bits);
    logic signed [MAX_W-1:0] bias;
    bias = (MAX_W'(1) << bits) - MAX_W'(1);
    if (p[MAX_W-1] && ((p & bias) != '0)) deq = (p + bias) >>> bits;
    else                                   deq = p >>> bits;
  endfunction

endpackage

// File: rtl/fir_decim_mac_unit.sv
// Multiply, dequantize and accumulate one tap per cycle; the running sum
// including the current term is exposed for the final latch.
module fir_mac_unit
  import fir_decim_pkg::*;
#(
  parameter int unsigned DATA_W = Q_W,
  parameter int unsigned BITS   = Q_BITS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] coeff,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] sum_c
);

  logic signed [DATA_W-1:0] prod_c;
  logic        [DATA_W-1:0] acc;

  // Product keeps only the low DATA_W bits, matching integer wrap.
  assign prod_c = $signed(coeff) * $signed(sample);
  assign sum_c  = acc + DATA_W'(deq(MAX_W'(prod_c), BITS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  acc <= '0;
    else if (clr)  acc <= '0;
    else if (en)   acc <= sum_c;
  end

endmodule

// File: rtl/fir_decim.sv
// Streaming decimating FIR: collects DECIM samples, then runs TAPS MAC cycles
// through a single multiplier and presents one output with valid/ready.
module fir_decim
  import fir_decim_pkg::*;
#(
  parameter int unsigned TAPS   = MAX_TAPS,
  parameter int unsigned DECIM  = AUDIO_DECIM,
  parameter int unsigned DATA_W = Q_W,
  parameter int unsigned BITS   = Q_BITS
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [TAPS*DATA_W-1:0] coeff,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PH_W  = $clog2(DECIM + 1);

  fir_state_t        state, state_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;
  logic [TAP_W-1:0]  tap, tap_nxt;
  logic              out_valid_nxt;
  logic              shift_c, mac_clr_c, mac_en_c, out_load_c;
  logic [DATA_W-1:0] hist [TAPS];
  logic [DATA_W-1:0] coeff_sel_c;
  logic [DATA_W-1:0] acc_sum_c;

  assign coeff_sel_c = coeff[32'(tap) * DATA_W +: DATA_W];

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .BITS   (BITS)
  ) u_mac (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (mac_clr_c),
    .en      (mac_en_c),
    .coeff   (coeff_sel_c),
    .sample  (hist[tap]),
    .sum_c   (acc_sum_c)
  );

  // Next-state and control decode.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    tap_nxt       = tap;
    out_valid_nxt = out_valid;
    shift_c       = 1'b0;
    mac_clr_c     = 1'b0;
    mac_en_c      = 1'b0;
    out_load_c    = 1'b0;
    unique case (state)
      COLLECT: begin
        if (in_valid && in_ready) begin
          shift_c = 1'b1;
          if (phase + PH_W'(1) == PH_W'(DECIM)) begin
            phase_nxt = '0;
            tap_nxt   = '0;
            mac_clr_c = 1'b1;
            state_nxt = MAC;
          end else begin
            phase_nxt = phase + PH_W'(1);
          end
        end
      end
      MAC: begin
        mac_en_c = 1'b1;
        if (tap == TAP_W'(TAPS - 1)) begin
          out_load_c    = 1'b1;
          out_valid_nxt = 1'b1;
          tap_nxt       = '0;
          state_nxt     = OUT;
        end else begin
          tap_nxt = tap + TAP_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= COLLECT;
      phase     <= '0;
      tap       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      tap       <= tap_nxt;
      in_ready  <= (state_nxt == COLLECT);
      out_valid <= out_valid_nxt;
      if (out_load_c) out_data <= acc_sum_c;
    end
  end

  // Sample history, newest at index 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(TAPS); k++) hist[k] <= '0;
    end else if (shift_c) begin
      hist[0] <= in_data;
      for (int k = 1; k < int'(TAPS); k++) hist[k] <= hist[k-1];
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
// Self-checking bench for fir_decim: table-driven single-output vectors plus
// streaming, backpressure, reset and DECIM=1 sequences checked via scoreboard.
`timescale 1ns/1ps
module tb_fir_decim;

  localparam int unsigned W  = 32;
  localparam int unsigned T8 = 32;
  localparam int unsigned D8 = 8;
  localparam int unsigned T1 = 4;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic [T8*W-1:0] coeff8 = '0;
  logic [W-1:0]    in_data8 = '0;
  logic            in_valid8 = 1'b0;
  logic            in_ready8;
  logic [W-1:0]    out_data8;
  logic            out_valid8;
  logic            out_ready8 = 1'b1;
  logic [T1*W-1:0] coeff1 = '0;
  logic [W-1:0]    in_data1 = '0;
  logic            in_valid1 = 1'b0;
  logic            in_ready1;
  logic [W-1:0]    out_data1;
  logic            out_valid1;
  logic            out_ready1 = 1'b1;

  always #5 clock = ~clock;

  fir_decim #(.TAPS(T8), .DECIM(D8), .DATA_W(W), .BITS(10)) dut8 (
    .clock(clock), .reset_n(reset_n), .coeff(coeff8),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8));

  fir_decim #(.TAPS(T1), .DECIM(1), .DATA_W(W), .BITS(10)) dut1 (
    .clock(clock), .reset_n(reset_n), .coeff(coeff1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1));

  typedef struct { int y; string tag; } exp_t;
  typedef struct { string name; int cmode; int s_first; int s_mid; int s_last; int y; } row_t;

  exp_t  q8[$];
  exp_t  q1[$];
  row_t  rows[7];
  int    errors = 0;
  int    checks = 0;
  int    mc8[T8];
  int    mh8[T8];
  int    mph8 = 0;
  int    mc1[T1];
  int    mh1[T1];
  bit    use_model = 1'b1;
  string tag8 = "none";
  string tag1 = "none";

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // SV signed division truncates toward zero, matching the required DEQ.
  function automatic int model_y8();
    int y = 0;
    for (int k = 0; k < int'(T8); k++) y += (mc8[k] * mh8[k]) / 1024;
    return y;
  endfunction

  function automatic int model_y1();
    int y = 0;
    for (int k = 0; k < int'(T1); k++) y += (mc1[k] * mh1[k]) / 1024;
    return y;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) check("dut8_unexpected_out", int'(out_data8), -999999);
      else begin e = q8.pop_front(); check(e.tag, int'(out_data8), e.y); end
    end
    if (reset_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("dut1_unexpected_out", int'(out_data1), -999999);
      else begin e = q1.pop_front(); check(e.tag, int'(out_data1), e.y); end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    q8.delete();
    q1.delete();
    for (int k = 0; k < int'(T8); k++) mh8[k] = 0;
    for (int k = 0; k < int'(T1); k++) mh1[k] = 0;
    mph8 = 0;
  endtask

  // cmode: 0 unit, 1 c0=1 only, 2 ramp k*1024, 3 c0=-1536 only
  task automatic do_reset(input int cmode);
    reset_n   = 1'b0;
    in_valid8 = 1'b0;
    in_valid1 = 1'b0;
    for (int k = 0; k < int'(T8); k++) begin
      case (cmode)
        0:       mc8[k] = 1024;
        1:       mc8[k] = (k == 0) ? 1 : 0;
        2:       mc8[k] = k * 1024;
        default: mc8[k] = (k == 0) ? -1536 : 0;
      endcase
      coeff8[k*W +: W] = W'(mc8[k]);
    end
    model_clear();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send8(input int x);
    int   n = 0;
    exp_t e;
    in_data8  = W'(x);
    in_valid8 = 1'b1;
    while (!in_ready8 && n < 400) begin tick(); n++; end
    if (!in_ready8) check("send8_timeout", 0, 1);
    else begin
      tick();
      for (int k = int'(T8) - 1; k > 0; k--) mh8[k] = mh8[k-1];
      mh8[0] = x;
      mph8++;
      if (mph8 == int'(D8)) begin
        mph8 = 0;
        if (use_model) begin e.y = model_y8(); e.tag = tag8; q8.push_back(e); end
      end
    end
    in_valid8 = 1'b0;
  endtask

  task automatic send1(input int x);
    int   n = 0;
    exp_t e;
    in_data1  = W'(x);
    in_valid1 = 1'b1;
    while (!in_ready1 && n < 100) begin tick(); n++; end
    if (!in_ready1) check("send1_timeout", 0, 1);
    else begin
      tick();
      for (int k = int'(T1) - 1; k > 0; k--) mh1[k] = mh1[k-1];
      mh1[0] = x;
      e.y = model_y1();
      e.tag = tag1;
      q1.push_back(e);
    end
    in_valid1 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 2000) begin tick(); n++; end
    check("drain_pending", q8.size() + q1.size(), 0);
  endtask

  task automatic wait_valid8();
    int n = 0;
    while (!out_valid8 && n < 200) begin tick(); n++; end
    check("wait_out_valid", int'(out_valid8), 1);
  endtask

  initial begin
    int   n;
    int   ir_bad;
    exp_t e;

    rows[0] = '{"unit_8x1024",  0, 1024,   1024, 1024,   8192};
    rows[1] = '{"trunc_old_m1", 1, -1,     0,    0,      0};
    rows[2] = '{"trunc_m1024",  1, 0,      0,    -1024,  -1};
    rows[3] = '{"neg_c_neg_x",  3, 0,      0,    -3,     4};
    rows[4] = '{"neg_c_pos_x",  3, 0,      0,    3,      -4};
    rows[5] = '{"ramp_oldest",  2, 1,      0,    0,      7};
    rows[6] = '{"wrap_prod",    0, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, -8};

    for (int k = 0; k < int'(T1); k++) begin
      mc1[k] = (k == 0) ? 1 : 0;
      coeff1[k*W +: W] = W'(mc1[k]);
    end

    #1;
    do_reset(0);
    check("rst_out_valid", int'(out_valid8), 0);
    check("rst_out_data", int'(out_data8), 0);
    check("rst_in_ready", int'(in_ready8), 1);
    check("rst_in_ready_d1", int'(in_ready1), 1);

    // Table of single-output vectors, each from a clean reset
    use_model = 1'b0;
    foreach (rows[i]) begin
      do_reset(rows[i].cmode);
      send8(rows[i].s_first);
      repeat (6) send8(rows[i].s_mid);
      send8(rows[i].s_last);
      e.y = rows[i].y;
      e.tag = rows[i].name;
      q8.push_back(e);
      wait_drain();
    end
    use_model = 1'b1;

    // Streaming with latency and in_ready check on the first pass
    do_reset(0);
    tag8 = "stream";
    repeat (8) send8(1024);
    n = 0;
    ir_bad = 0;
    while (!out_valid8 && n < 100) begin
      if (in_ready8) ir_bad++;
      tick();
      n++;
    end
    check("latency_cycles", n, int'(T8));
    check("in_ready_during_mac", ir_bad, 0);
    check("in_ready_during_out", int'(in_ready8), 0);
    repeat (32) send8(1024);
    wait_drain();

    // Impulse response through ramp coefficients
    do_reset(2);
    tag8 = "impulse";
    send8(1);
    repeat (39) send8(0);
    wait_drain();

    // Backpressure: output held, no input consumed
    do_reset(0);
    tag8 = "bp_first";
    out_ready8 = 1'b0;
    repeat (8) send8(1024);
    wait_valid8();
    in_valid8 = 1'b1;
    in_data8  = 777;
    repeat (20) begin
      tick();
      check("bp_data_hold", int'(out_data8), 8192);
      check("bp_in_ready", int'(in_ready8), 0);
      check("bp_valid_hold", int'(out_valid8), 1);
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    tick();
    check("bp_release_valid", int'(out_valid8), 0);
    check("bp_release_ready", int'(in_ready8), 1);
    tag8 = "bp_after";
    repeat (8) send8(2048);
    wait_drain();

    // Reset in the middle of the MAC pass
    do_reset(0);
    tag8 = "pre_rst";
    repeat (8) send8(3000);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("rst_mac_valid", int'(out_valid8), 0);
    model_clear();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("rst_mac_in_ready", int'(in_ready8), 1);
    tag8 = "post_rst";
    repeat (8) send8(1024);
    wait_drain();

    // Reset while holding an output
    out_ready8 = 1'b0;
    tag8 = "rst_out";
    repeat (8) send8(1024);
    wait_valid8();
    reset_n = 1'b0;
    #1;
    check("rst_out_valid_async", int'(out_valid8), 0);
    check("rst_out_data_async", int'(out_data8), 0);
    model_clear();
    out_ready8 = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("rst_out_in_ready", int'(in_ready8), 1);

    // DECIM=1: every input produces an output
    tag1 = "d1_m1";     send1(-1);
    tag1 = "d1_m1024";  send1(-1024);
    tag1 = "d1_2048";   send1(2048);
    tag1 = "d1_m2047";  send1(-2047);
    tag1 = "d1_5000";   send1(5000);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
